// File: rtl/fifo.sv
// First-word-fall-through FIFO with an inline register array and modulo-DEPTH
// pointers, so non-power-of-2 depths work without wasted storage.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enq_i,
  input  logic                  deq_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  full_o_n,
  output logic                  empty_o_n
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0]      r_count;

  logic w_full, w_empty, w_enq_ok, w_deq_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  // At full, a same-cycle dequeue frees the slot the enqueue is about to use.
  assign w_deq_ok = deq_i && !w_empty;
  assign w_enq_ok = enq_i && (!w_full || deq_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_deq_ok) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_enq_ok, w_deq_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is never cleared; the empty gate on dout_o hides stale words.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_enq_ok) r_mem[r_wr_ptr] <= din_i;
  end

  assign dout_o    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign full_o_n  = !w_full;
  assign empty_o_n = !w_empty;
endmodule

// File: tb/tb_fifo.sv
// Bench for fifo: directed table on a 4x8 instance, multi-cycle corner sequences,
// a 249x1 delay line across pointer wraps, and a queue-model random run.
module tb_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4 x 8 instance
  logic       a_rst, a_enq, a_deq;
  logic [7:0] a_din, a_dout;
  logic       a_full_n, a_empty_n;
  // 249 x 1 instance
  logic       b_rst, b_enq, b_deq;
  logic [0:0] b_din, b_dout;
  logic       b_full_n, b_empty_n;

  fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) u_a (
    .clk_i(clk), .rst_i(a_rst), .enq_i(a_enq), .deq_i(a_deq), .din_i(a_din),
    .dout_o(a_dout), .full_o_n(a_full_n), .empty_o_n(a_empty_n));

  fifo #(.DATA_WIDTH(1), .FIFO_DEPTH(249)) u_b (
    .clk_i(clk), .rst_i(b_rst), .enq_i(b_enq), .deq_i(b_deq), .din_i(b_din),
    .dout_o(b_dout), .full_o_n(b_full_n), .empty_o_n(b_empty_n));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst, enq, deq;
    logic [7:0] din, dout;
    logic       full_n, empty_n;
  } vec_t;

  function automatic vec_t v(input logic rst, enq, deq, input logic [7:0] din, dout,
                             input logic full_n, empty_n);
    vec_t t;
    t.rst = rst; t.enq = enq; t.deq = deq; t.din = din;
    t.dout = dout; t.full_n = full_n; t.empty_n = empty_n;
    return t;
  endfunction

  vec_t tbl[$];
  logic q[$];          // delay-line history of accepted enqueues
  logic [7:0] mq[$];   // random-run model queue

  initial begin
    a_rst = 1'b1; a_enq = 1'b0; a_deq = 1'b0; a_din = '0;
    b_rst = 1'b1; b_enq = 1'b0; b_deq = 1'b0; b_din = '0;

    //        rst enq deq din    dout  fn  en
    tbl.push_back(v(1, 0, 0, 8'h00, 8'h00, 1, 0));  // reset
    tbl.push_back(v(0, 0, 0, 8'h00, 8'h00, 1, 0));  // idle
    tbl.push_back(v(0, 1, 0, 8'h11, 8'h11, 1, 1));
    tbl.push_back(v(0, 1, 0, 8'h22, 8'h11, 1, 1));
    tbl.push_back(v(0, 1, 0, 8'h33, 8'h11, 1, 1));
    tbl.push_back(v(0, 1, 0, 8'h44, 8'h11, 0, 1));  // full
    tbl.push_back(v(0, 1, 0, 8'h55, 8'h11, 0, 1));  // ignored at full
    tbl.push_back(v(0, 0, 1, 8'h00, 8'h22, 1, 1));
    tbl.push_back(v(0, 0, 1, 8'h00, 8'h33, 1, 1));
    tbl.push_back(v(0, 0, 1, 8'h00, 8'h44, 1, 1));
    tbl.push_back(v(0, 0, 1, 8'h00, 8'h00, 1, 0));  // empty again
    tbl.push_back(v(0, 0, 1, 8'h00, 8'h00, 1, 0));  // deq on empty ignored
    tbl.push_back(v(0, 1, 1, 8'hA5, 8'hA5, 1, 1));  // enq+deq on empty
    tbl.push_back(v(0, 0, 1, 8'h00, 8'h00, 1, 0));
    tbl.push_back(v(0, 1, 0, 8'h01, 8'h01, 1, 1));
    tbl.push_back(v(0, 1, 0, 8'h02, 8'h01, 1, 1));
    tbl.push_back(v(1, 1, 0, 8'h99, 8'h00, 1, 0));  // reset mid-fill wins over enq
    tbl.push_back(v(0, 1, 0, 8'h3C, 8'h3C, 1, 1));
    tbl.push_back(v(0, 1, 0, 8'h4D, 8'h3C, 1, 1));
    tbl.push_back(v(0, 1, 0, 8'h5E, 8'h3C, 1, 1));
    tbl.push_back(v(0, 1, 0, 8'h6F, 8'h3C, 0, 1));  // full, pointers have wrapped
    tbl.push_back(v(0, 1, 1, 8'h70, 8'h4D, 0, 1));  // enq+deq at full
    tbl.push_back(v(0, 0, 1, 8'h00, 8'h5E, 1, 1));
    tbl.push_back(v(0, 0, 1, 8'h00, 8'h6F, 1, 1));
    tbl.push_back(v(0, 0, 1, 8'h00, 8'h70, 1, 1));
    tbl.push_back(v(0, 0, 1, 8'h00, 8'h00, 1, 0));

    foreach (tbl[i]) begin
      a_rst = tbl[i].rst; a_enq = tbl[i].enq; a_deq = tbl[i].deq; a_din = tbl[i].din;
      step();
      chk($sformatf("row%0d dout", i),    32'(a_dout),    32'(tbl[i].dout));
      chk($sformatf("row%0d full_n", i),  32'(a_full_n),  32'(tbl[i].full_n));
      chk($sformatf("row%0d empty_n", i), 32'(a_empty_n), 32'(tbl[i].empty_n));
    end
    a_enq = 1'b0; a_deq = 1'b0;

    // Delay line: once full, dout is the bit enqueued 249 accepted enqueues earlier.
    begin
      logic was_full;
      int n_full;
      was_full = 1'b0;
      n_full = 0;
      b_rst = 1'b0;
      for (int c = 0; c < 249 + 600; c++) begin
        logic bit_in;
        bit_in = 1'($urandom);
        b_enq = 1'b1;
        b_din = bit_in;
        b_deq = !b_full_n;
        q.push_back(bit_in);
        step();
        if (!b_full_n) was_full = 1'b1;
        if (was_full) begin
          n_full++;
          chk($sformatf("dly%0d full_n", c), 32'(b_full_n), 32'd0);
          chk($sformatf("dly%0d dout", c), 32'(b_dout), 32'(q[q.size() - 249]));
        end else begin
          chk($sformatf("dly%0d empty_n", c), 32'(b_empty_n), 32'd1);
        end
      end
      chk("dly cycles_full", 32'(n_full), 32'd601);
      b_enq = 1'b0; b_deq = 1'b0;
    end

    // Random enq/deq against a queue model; bias flips to reach both full and empty.
    a_rst = 1'b1;
    step();
    a_rst = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      logic e, d, e_ok, d_ok;
      logic [7:0] din;
      int bias;
      bias = ((c / 300) % 2 == 0) ? 75 : 25;
      e = ($urandom_range(99) < bias);
      d = ($urandom_range(99) < (100 - bias));
      din = 8'($urandom);
      e_ok = e && (mq.size() < 4 || d);
      d_ok = d && (mq.size() > 0);
      a_enq = e; a_deq = d; a_din = din;
      if (d_ok) void'(mq.pop_front());
      if (e_ok) mq.push_back(din);
      step();
      chk($sformatf("rnd%0d dout", c), 32'(a_dout), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
      chk($sformatf("rnd%0d full_n", c), 32'(a_full_n), 32'(mq.size() != 4));
      chk($sformatf("rnd%0d empty_n", c), 32'(a_empty_n), 32'(mq.size() != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
